clk_period_meter: RTL and testbench

//   Measures a divided or foreign clock (meas_clk) in clk_in cycles: period and high time.

---
 rtl/clk_period_meter.sv | 161 ++++++++++++++++
 tb/tb_clk_period_meter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// One-shot period / high-time meter: measures meas_clk in clk_in cycles after each start.
// meas_clk passes through a SYNC_STAGES-deep synchronizer (SYNC_STAGES must be at least 2).
`timescale 1ns/1ps

module clk_period_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             meas_clk,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_EDGE = 2'd1,
        MEASURE   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d;
    logic                   s;
    logic                   rise;
    logic                   fall;

    state_t                 state;
    state_t                 state_next;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_next;
    logic [CNT_W-1:0]       cnt_inc;
    logic [CNT_W-1:0]       hi;
    logic [CNT_W-1:0]       hi_next;
    logic                   seen_fall;
    logic                   seen_fall_next;
    logic [CNT_W-1:0]       period_next;
    logic [CNT_W-1:0]       high_time_next;
    logic                   timeout_next;
    logic                   done_next;

    assign s       = sync_q[SYNC_STAGES-1];
    assign rise    = s & ~s_d;
    assign fall    = ~s & s_d;
    assign cnt_inc = cnt + CNT_ONE;

    // Synchronizer and edge-detect flop run every cycle, independent of the FSM.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], meas_clk};
            s_d    <= s;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            cnt       <= '0;
            hi        <= '0;
            seen_fall <= 1'b0;
            period    <= '0;
            high_time <= '0;
            timeout   <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            busy      <= (state_next != IDLE);
            cnt       <= cnt_next;
            hi        <= hi_next;
            seen_fall <= seen_fall_next;
            period    <= period_next;
            high_time <= high_time_next;
            timeout   <= timeout_next;
            done      <= done_next;
        end
    end

    // Stopping one count short of all-ones means a saturated counter is never
    // reported as a period; it always ends as a timeout.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        hi_next        = hi;
        seen_fall_next = seen_fall;
        period_next    = period;
        high_time_next = high_time;
        timeout_next   = timeout;
        done_next      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next   = WAIT_EDGE;
                    cnt_next     = '0;
                    timeout_next = 1'b0;
                end
            end

            WAIT_EDGE: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (rise) begin
                    state_next     = MEASURE;
                    cnt_next       = CNT_ONE;
                    hi_next        = CNT_ONE;
                    seen_fall_next = 1'b0;
                end else if (cnt_inc == CNT_MAX) begin
                    state_next     = IDLE;
                    timeout_next   = 1'b1;
                    period_next    = '0;
                    high_time_next = '0;
                    done_next      = 1'b1;
                end else begin
                    cnt_next = cnt_inc;
                end
            end

            MEASURE: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (rise) begin
                    state_next     = IDLE;
                    period_next    = cnt;
                    high_time_next = hi;
                    done_next      = 1'b1;
                end else if (cnt_inc == CNT_MAX) begin
                    state_next     = IDLE;
                    timeout_next   = 1'b1;
                    period_next    = '0;
                    high_time_next = '0;
                    done_next      = 1'b1;
                end else begin
                    cnt_next = cnt_inc;
                    if (fall) begin
                        seen_fall_next = 1'b1;
                    end
                    if (s && !seen_fall) begin
                        hi_next = hi + CNT_ONE;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter (CNT_W=8): divider-derived and async meas_clk,
// timeout, abort, mid-measurement reset and start-while-busy.
`timescale 1ns/1ps

module tb_clk_period_meter;

    localparam int CNT_W = 8;

    logic             clk_in = 1'b0;
    logic             rst_n;
    logic             meas_clk;
    logic             start;
    logic             abort;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             timeout;

    int checks   = 0;
    int failures = 0;

    // Divider model: meas_clk toggles every div_n clk_in cycles while div_en is set.
    int   div_n   = 2;
    bit   div_en  = 1'b0;
    int   div_cnt = 0;
    logic div_clk = 1'b0;

    bit   async_mode = 1'b0;
    logic async_clk  = 1'b0;

    assign meas_clk = async_mode ? async_clk : div_clk;

    clk_period_meter #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(2)
    ) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .meas_clk (meas_clk),
        .start    (start),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .period   (period),
        .high_time(high_time),
        .timeout  (timeout)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (!div_en) begin
            div_cnt = 0;
            div_clk = 1'b0;
        end else if (div_cnt >= div_n - 1) begin
            div_cnt = 0;
            div_clk = ~div_clk;
        end else begin
            div_cnt = div_cnt + 1;
        end
    end

    // 187.5 ns half period against a 10 ns clk_in gives 37.5 cycles per period.
    initial begin
        #3.7;
        forever #187.5 async_clk = ~async_clk;
    end

    typedef struct {
        int div;
        int exp_period;
        int exp_high;
        int max_cycles;
    } vec_t;

    vec_t vecs [6];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkRange(input string name, input int actual, input int lo, input int hi);
        checks++;
        if (actual < lo || actual > hi) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic a);
        @(negedge clk_in);
        start = s;
        abort = a;
        @(negedge clk_in);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic waitDone(input int bound, output int cycles, output bit seen);
        cycles = 1;
        seen   = 1'b0;
        while (!seen && cycles <= bound) begin
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                @(negedge clk_in);
                cycles++;
            end
        end
    endtask

    task automatic setDivider(input int n);
        @(negedge clk_in);
        div_en = 1'b0;
        div_n  = n;
        repeat (2) @(negedge clk_in);
        div_en = 1'b1;
        repeat (2 * n + 4) @(negedge clk_in);
    endtask

    task automatic waitMeasRise(input int bound, output bit seen);
        logic prev;
        prev = meas_clk;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk_in);
            if (meas_clk === 1'b1 && prev === 1'b0) seen = 1'b1;
            prev = meas_clk;
        end
    endtask

    initial begin
        int  cycles;
        bit  seen;
        int  done_count;
        int  busy_cycles;
        int  last_period;
        int  last_high;

        vecs[0] = '{div: 2,  exp_period: 4,  exp_high: 2,  max_cycles: 10};
        vecs[1] = '{div: 1,  exp_period: 2,  exp_high: 1,  max_cycles: 6};
        vecs[2] = '{div: 5,  exp_period: 10, exp_high: 5,  max_cycles: 22};
        vecs[3] = '{div: 3,  exp_period: 6,  exp_high: 3,  max_cycles: 14};
        vecs[4] = '{div: 7,  exp_period: 14, exp_high: 7,  max_cycles: 30};
        vecs[5] = '{div: 16, exp_period: 32, exp_high: 16, max_cycles: 66};

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        repeat (4) @(negedge clk_in);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_period", period, 0);
        checkOutput("reset_high_time", high_time, 0);
        checkOutput("reset_timeout", timeout, 0);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            setDivider(vecs[v].div);
            applyStimulus(1'b1, 1'b0);
            checkOutput($sformatf("div%0d_busy", vecs[v].div), busy, 1);
            waitDone(200, cycles, seen);
            checkOutput($sformatf("div%0d_done_seen", vecs[v].div), seen, 1);
            checkRange($sformatf("div%0d_latency", vecs[v].div), cycles, 1, vecs[v].max_cycles);
            checkOutput($sformatf("div%0d_period", vecs[v].div), period, vecs[v].exp_period);
            checkOutput($sformatf("div%0d_high_time", vecs[v].div), high_time, vecs[v].exp_high);
            checkOutput($sformatf("div%0d_timeout", vecs[v].div), timeout, 0);
            @(negedge clk_in);
            checkOutput($sformatf("div%0d_done_pulse", vecs[v].div), done, 0);
        end
        last_period = 32;
        last_high   = 16;

        // Abort well inside a 100-cycle MEASURE phase.
        setDivider(50);
        applyStimulus(1'b1, 1'b0);
        waitMeasRise(250, seen);
        checkOutput("abort_meas_rise_seen", seen, 1);
        repeat (10) @(negedge clk_in);
        checkOutput("abort_busy_before", busy, 1);
        abort = 1'b1;
        @(negedge clk_in);
        abort = 1'b0;
        checkOutput("abort_busy_after", busy, 0);
        done_count = 0;
        for (int i = 0; i < 150; i++) begin
            if (done === 1'b1) done_count++;
            @(negedge clk_in);
        end
        checkOutput("abort_no_done", done_count, 0);
        checkOutput("abort_period_kept", period, last_period);
        checkOutput("abort_high_kept", high_time, last_high);

        // Timeout: meas_clk held low, 255 WAIT_EDGE cycles then done.
        @(negedge clk_in);
        div_en = 1'b0;
        applyStimulus(1'b1, 1'b0);
        busy_cycles = 0;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (done === 1'b1) seen = 1'b1;
            else begin
                if (busy === 1'b1) busy_cycles++;
                @(negedge clk_in);
            end
        end
        checkOutput("timeout_done_seen", seen, 1);
        checkOutput("timeout_wait_cycles", busy_cycles, 255);
        checkOutput("timeout_flag", timeout, 1);
        checkOutput("timeout_period", period, 0);
        checkOutput("timeout_high_time", high_time, 0);
        checkOutput("timeout_busy", busy, 0);

        setDivider(2);
        checkOutput("timeout_sticky", timeout, 1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("timeout_cleared", timeout, 0);
        waitDone(50, cycles, seen);
        checkOutput("after_timeout_done_seen", seen, 1);
        checkOutput("after_timeout_period", period, 4);
        checkOutput("after_timeout_high", high_time, 2);

        // Reset in the middle of a measurement.
        setDivider(10);
        applyStimulus(1'b1, 1'b0);
        waitMeasRise(100, seen);
        repeat (6) @(negedge clk_in);
        rst_n = 1'b0;
        @(negedge clk_in);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_period", period, 0);
        checkOutput("midrst_high_time", high_time, 0);
        checkOutput("midrst_timeout", timeout, 0);
        rst_n = 1'b1;

        // Start pulses while busy must not produce extra results.
        setDivider(3);
        applyStimulus(1'b1, 1'b0);
        done_count = 0;
        for (int i = 0; i < 60; i++) begin
            if (done === 1'b1) begin
                done_count++;
                checkOutput("busy_start_period", period, 6);
                checkOutput("busy_start_high", high_time, 3);
            end
            start = (i < 8 && busy === 1'b1 && (i % 2) == 0) ? 1'b1 : 1'b0;
            @(negedge clk_in);
        end
        start = 1'b0;
        checkOutput("busy_start_one_done", done_count, 1);

        // Asynchronous meas_clk, 37.5 clk_in cycles period, 50% duty.
        @(negedge clk_in);
        div_en     = 1'b0;
        async_mode = 1'b1;
        repeat (10) @(negedge clk_in);
        for (int m = 0; m < 4; m++) begin
            applyStimulus(1'b1, 1'b0);
            waitDone(150, cycles, seen);
            checkOutput($sformatf("async%0d_done_seen", m), seen, 1);
            checkRange($sformatf("async%0d_period", m), period, 37, 38);
            checkRange($sformatf("async%0d_high_time", m), high_time, 18, 19);
            checkOutput($sformatf("async%0d_timeout", m), timeout, 0);
            repeat (m * 7 + 3) @(negedge clk_in);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
